ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB-Lite slave that sits downstream of ahb_design_top on the shared ahb_if bus. It consumes the address/control and write data that stage drives, and returns HRDATA/HREADYOUT/HRESP.
- Backs a word-addressed on-chip SRAM with byte-lane writes.
- Inserts a programmable number of wait states.
- Issues the two-cycle AHB ERROR response for illegal accesses.

Parameters:
BUS_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported.
MEM_DEPTH, 256, number of DATA_WIDTH words; must be a power of two.
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15).

Ports:
HCLK  input  1  bus clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select (address phase)
HADDR  input  BUS_WIDTH  byte address
HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size
HBURST  input  3  burst type, ignored (each beat is decoded independently)
HWDATA  input  DATA_WIDTH  write data (data phase)
HREADY  input  1  bus-level ready (previous transfer complete)
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  DATA_WIDTH  read data

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, pending write dropped. SRAM contents are not reset.
- Reset asserted mid-transfer: an uncommitted write is discarded and outputs return to reset values immediately.
- Address phase accept: HSEL && HREADY && HTRANS[1]. On accept, latch addr, write, size and an error flag.
- IDLE or BUSY with HSEL: zero-wait OKAY; no data phase.
- Error flag is set when any of these hold:
  - word index HADDR[BUS_WIDTH-1:2] >= MEM_DEPTH;
  - HSIZE > 3'b010;
  - misaligned: half-word with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states IDLE, WAIT, LAST, ERR1, ERR2:
  - IDLE, accept with error -> ERR1.
  - IDLE, accept OK -> WAIT if WAIT_STATES>0, else LAST.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements; -> LAST when it reaches 1.
  - LAST: HREADYOUT=1, HRESP=0, transfer completes. Next state is decided by the address phase sampled in this same cycle (pipelined back-to-back).
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is decided by the address phase sampled this cycle; HTRANS=IDLE here is the normal cancel case.
- Writes:
  - Committed on the rising edge that ends LAST.
  - Byte strobes come from the latched size and addr[1:0], little-endian: byte -> 1 lane; half -> lanes {1,0} or {3,2}; word -> all lanes.
  - Errored writes never modify memory.
- Reads:
  - HRDATA is the full word at the latched index, combinational from the array during WAIT/LAST of a read. HRDATA=0 otherwise.
  - A read data phase that directly follows a write data phase to the same word returns the new data, because the write commits on the edge that starts the read's data phase.
- Wait counter is 4 bits and reloads to WAIT_STATES on every OKAY accept.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - hsize_t constants BYTE=3'b000, HALF=3'b001, WORD=3'b010;
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1;
  - slave_state_t enum for the FSM.
- One sub-module, ahb_sram_bytemem: MEM_DEPTH x 4-byte array with write-enable, 4-bit byte strobe, index and async read port. The FSM, decode and strobe generation live in ahb_sram_slave.

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> both HREADYOUT=1 with no stall; read data phase HRDATA=0xDEADBEEF.
2. Byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344. Half write 0x5566 to 0x10 -> read returns 0xAA225566.
3. WAIT_STATES=2: read 0x10 -> HREADYOUT 0,0,1 across the data phase; HRDATA valid with the final cycle. Write with waits commits only after the final cycle.
4. Word read at 0x02 (misaligned) and at 0x400 (out of range, depth 256) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1). Errored write to 0x02 leaves memory unchanged.
5. HSEL=1 with HTRANS=IDLE, then BUSY -> HREADYOUT=1, HRESP=0 every cycle, memory untouched. HSEL=0 with NONSEQ -> ignored.
6. Assert HRESETn=0 during WAIT of a write to 0x20 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; after release, read 0x20 returns its prior value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the SRAM slave.
package ahb_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HSIZE_W  = 3;
  localparam int unsigned LANES    = 4;

  typedef enum logic [HTRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef logic [HSIZE_W-1:0] hsize_t;

  localparam hsize_t BYTE = 3'b000;
  localparam hsize_t HALF = 3'b001;
  localparam hsize_t WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Little-endian byte-lane enables for a legal (aligned, <= word) access.
  function automatic logic [LANES-1:0] byte_strobe(hsize_t size, logic [1:0] lane);
    logic [LANES-1:0] strb;
    case (size)
      BYTE:    strb = LANES'(4'b0001 << lane);
      HALF:    strb = lane[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB-Lite bus bundle between a master stage and the SRAM slave.
interface ahb_if
  import ahb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  HSEL;
  logic [BUS_WIDTH-1:0]  HADDR;
  htrans_t               HTRANS;
  logic                  HWRITE;
  hsize_t                HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_bytemem.sv
// Word-organised SRAM with per-byte write strobes and an asynchronous read port.
module ahb_sram_bytemem #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned LANE_N = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANE_N); i++) begin
        if (strb[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address decode, wait-state / error FSM, byte-lane writes.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_if.slave bus
);

  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WORD_W = BUS_WIDTH - 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LANE_N = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam bit HAS_WAIT = (WAIT_STATES != 0);

  slave_state_t          state_q;
  slave_state_t          state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  ready_q;
  logic                  ready_d;
  logic                  resp_q;
  logic                  resp_d;

  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lane_q;
  hsize_t                size_q;
  logic                  write_q;
  logic                  err_q;

  logic                  accept_c;
  logic [WORD_W-1:0]     word_c;
  logic                  oor_c;
  logic                  bad_size_c;
  logic                  misalign_c;
  logic                  err_c;
  logic                  we_c;
  logic                  rd_active_c;
  logic [LANE_N-1:0]     strb_c;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_bits;

  // Address-phase decode: accept only a selected, active transfer when the bus is ready.
  assign accept_c   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign word_c     = bus.HADDR[BUS_WIDTH-1:2];
  assign oor_c      = (word_c >= WORD_W'(MEM_DEPTH));
  assign bad_size_c = (bus.HSIZE > WORD);
  assign misalign_c = ((bus.HSIZE == HALF) && bus.HADDR[0]) ||
                      ((bus.HSIZE == WORD) && (bus.HADDR[1:0] != 2'b00));
  assign err_c      = oor_c || bad_size_c || misalign_c;

  // HTRANS[0] (BUSY vs IDLE, SEQ vs NONSEQ) and HBURST do not affect decoding.
  assign unused_bits = ^{bus.HTRANS[0], bus.HBURST};

  // Latch the accepted address phase for use during its data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= BYTE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept_c) begin
      idx_q   <= bus.HADDR[IDX_W+1:2];
      lane_q  <= bus.HADDR[1:0];
      size_q  <= bus.HSIZE;
      write_q <= bus.HWRITE;
      err_q   <= err_c;
    end
  end

  // FSM state, wait counter and registered handshake outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  // Next state; completing states (IDLE/LAST/ERR2) also sample the pipelined address phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    resp_d  = HRESP_OKAY;

    case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (err_c) begin
            state_d = ST_ERR1;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = HAS_WAIT ? ST_WAIT : ST_LAST;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_LAST;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Write commits on the edge that ends LAST; errored transfers never reach LAST.
  assign we_c        = (state_q == ST_LAST) && write_q && !err_q;
  assign strb_c      = byte_strobe(size_q, lane_q);
  assign rd_active_c = ((state_q == ST_WAIT) || (state_q == ST_LAST)) && !write_q;

  ahb_sram_bytemem #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (we_c),
    .strb  (strb_c),
    .idx   (idx_q),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = rd_active_c ? mem_rdata : '0;

endmodule
